// File: rtl/par_sink_to_memory_pkg.sv
// Shared definitions for the NoC destination sink: flit geometry,
// FSM state encoding and the flit layout used to split a popped entry.
package par_sink_to_memory_pkg;

    localparam int PAYLOAD_SIZE = 8;
    localparam int ADDR_BITS    = 4;
    localparam int NUM_NODES    = 16;
    localparam int FLIT_WIDTH   = PAYLOAD_SIZE + ADDR_BITS;

    typedef enum logic {
        ST_RECV = 1'b0,
        ST_DONE = 1'b1
    } sink_state_t;

    typedef struct packed {
        logic [PAYLOAD_SIZE-1:0] payload;
        logic [ADDR_BITS-1:0]    dest;
    } flit_t;

    // A node id of -1 means "accept any destination"
    function automatic logic isMisrouted(input logic [ADDR_BITS-1:0] dest, input int nodeId);
        return (nodeId != -1) && (int'(dest) != nodeId);
    endfunction

endpackage

// File: rtl/par_sink_to_memory_if.sv
// Flit delivery channel between a router output port (master) and a
// destination sink (slave). busy is the sink's early backpressure.
interface par_sink_to_memory_if;
    import par_sink_to_memory_pkg::*;

    logic [FLIT_WIDTH-1:0] item_in;
    logic                  valid;
    logic                  busy;

    modport master (output item_in, output valid, input busy);
    modport slave  (input item_in, input valid, output busy);

endinterface

// File: rtl/par_sink_to_memory_sync_fifo.sv
// Generic synchronous FIFO with registered pointers and a show-ahead read
// port. A push is honoured when full only if a pop happens in the same
// cycle, so a full FIFO can stream at one entry per cycle.
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [width-1:0]       i_din,
    output logic [width-1:0]       o_dout,
    output logic [$clog2(depth):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(depth));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty && !reset;
    assign w_do_push = i_push && (!o_full || w_do_pop) && !reset;
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/par_sink_to_memory.sv
// Destination-side traffic sink: buffers incoming flits, raises busy one
// slot early, drains at a programmable rate, reassembles the payload
// stream into msg_mem and keeps sticky error flags for post-run scoring.
module par_sink_to_memory
    import par_sink_to_memory_pkg::*;
#(
    parameter int id           = -1,
    parameter int msg_size     = 12,
    parameter int fifo_depth   = 4,
    parameter int drain_period = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    par_sink_to_memory_if.slave     bus,
    output logic [15:0]             o_rx_count,
    output logic                    o_rx_strobe,
    output logic [PAYLOAD_SIZE-1:0] o_rx_payload,
    output logic                    o_done,
    output logic                    o_err_misroute,
    output logic                    o_err_overflow,
    output logic                    o_err_extra
);

    localparam int CNT_W = $clog2(fifo_depth) + 1;
    localparam int IDX_W = (msg_size > 1) ? $clog2(msg_size) : 1;
    localparam int DRN_W = (drain_period > 1) ? $clog2(drain_period) : 1;

    logic [FLIT_WIDTH-1:0]   w_fifo_dout;
    logic [CNT_W-1:0]        w_fifo_count;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_pop;
    logic                    w_push_ok;
    logic                    w_overflow;
    logic [CNT_W-1:0]        w_next_occ;
    flit_t                   w_pop_flit;

    logic [DRN_W-1:0]        r_drain_cnt;
    sink_state_t             r_state;
    sink_state_t             w_state_next;
    logic                    w_mem_wr;
    logic                    w_extra;
    logic [IDX_W-1:0]        r_wr_idx;

    logic                    r_busy;
    logic [15:0]             r_rx_count;
    logic                    r_rx_strobe;
    logic [PAYLOAD_SIZE-1:0] r_rx_payload;
    logic                    r_err_misroute;
    logic                    r_err_overflow;
    logic                    r_err_extra;

    logic [PAYLOAD_SIZE-1:0] msg_mem [msg_size];

    sync_fifo #(
        .width (FLIT_WIDTH),
        .depth (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.valid),
        .i_pop   (w_pop),
        .i_din   (bus.item_in),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A pop needs a drain slot and something queued; the full check for an
    // incoming flit sees the occupancy after that pop.
    assign w_pop      = (r_drain_cnt == '0) && !w_fifo_empty && !reset;
    assign w_push_ok  = bus.valid && (!w_fifo_full || w_pop) && !reset;
    assign w_overflow = bus.valid && w_fifo_full && !w_pop;
    assign w_next_occ = w_fifo_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    assign w_pop_flit = flit_t'(w_fifo_dout);

    // Drain opportunity counter, free-running 0..drain_period-1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain_cnt <= '0;
        end else if (r_drain_cnt == DRN_W'(drain_period - 1)) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
        end
    end

    // Busy leaves one free slot for the flit already launched upstream
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_occ >= CNT_W'(fifo_depth - 1));
        end
    end

    // Message FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RECV;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: store pops until the message is complete, then only flag extras
    always_comb begin
        w_state_next = r_state;
        w_mem_wr     = 1'b0;
        w_extra      = 1'b0;
        case (r_state)
            ST_RECV: begin
                if (w_pop) begin
                    w_mem_wr = 1'b1;
                    if (r_wr_idx == IDX_W'(msg_size - 1)) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_pop) begin
                    w_extra = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RECV;
            end
        endcase
    end

    // Write index into the message memory
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_idx <= '0;
        end else if (w_mem_wr) begin
            r_wr_idx <= r_wr_idx + IDX_W'(1);
        end
    end

    // Message memory keeps its contents across reset so a run can be inspected afterwards
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            msg_mem[r_wr_idx] <= w_pop_flit.payload;
        end
    end

    // Per-pop statistics and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_count     <= '0;
            r_rx_strobe    <= 1'b0;
            r_rx_payload   <= '0;
            r_err_misroute <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_extra    <= 1'b0;
        end else begin
            r_rx_strobe <= w_pop;
            if (w_pop) begin
                r_rx_payload <= w_pop_flit.payload;
                if (r_rx_count != 16'hFFFF) begin
                    r_rx_count <= r_rx_count + 16'd1;
                end
            end
            if (w_pop && isMisrouted(w_pop_flit.dest, id)) begin
                r_err_misroute <= 1'b1;
            end
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end
            if (w_extra) begin
                r_err_extra <= 1'b1;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign o_rx_count     = r_rx_count;
    assign o_rx_strobe    = r_rx_strobe;
    assign o_rx_payload   = r_rx_payload;
    assign o_done         = (r_state == ST_DONE);
    assign o_err_misroute = r_err_misroute;
    assign o_err_overflow = r_err_overflow;
    assign o_err_extra    = r_err_extra;

endmodule

// File: tb/tb_par_sink_to_memory.sv
// Directed bench for par_sink_to_memory. Three sinks share clock and reset:
// A drains every cycle, B every 4th cycle (backpressure, mid-run reset),
// C every 8th cycle (overflow). All expected values are hand-derived.
module tb_par_sink_to_memory;
    import par_sink_to_memory_pkg::*;

    logic clk = 1'b0;
    logic reset;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    int busyHits;
    int firstBusyStep;
    logic [7:0] expectB;

    par_sink_to_memory_if ifA ();
    par_sink_to_memory_if ifB ();
    par_sink_to_memory_if ifC ();

    logic [15:0] rxCountA, rxCountB, rxCountC;
    logic        rxStrobeA, rxStrobeB, rxStrobeC;
    logic [7:0]  rxPayloadA, rxPayloadB, rxPayloadC;
    logic        doneA, doneB, doneC;
    logic        errMisA, errMisB, errMisC;
    logic        errOvfA, errOvfB, errOvfC;
    logic        errExtA, errExtB, errExtC;

    par_sink_to_memory #(.id(3), .msg_size(12), .fifo_depth(4), .drain_period(1)) dutA (
        .clk(clk), .reset(reset), .bus(ifA),
        .o_rx_count(rxCountA), .o_rx_strobe(rxStrobeA), .o_rx_payload(rxPayloadA),
        .o_done(doneA), .o_err_misroute(errMisA), .o_err_overflow(errOvfA), .o_err_extra(errExtA)
    );

    par_sink_to_memory #(.id(3), .msg_size(12), .fifo_depth(4), .drain_period(4)) dutB (
        .clk(clk), .reset(reset), .bus(ifB),
        .o_rx_count(rxCountB), .o_rx_strobe(rxStrobeB), .o_rx_payload(rxPayloadB),
        .o_done(doneB), .o_err_misroute(errMisB), .o_err_overflow(errOvfB), .o_err_extra(errExtB)
    );

    par_sink_to_memory #(.id(3), .msg_size(12), .fifo_depth(4), .drain_period(8)) dutC (
        .clk(clk), .reset(reset), .bus(ifC),
        .o_rx_count(rxCountC), .o_rx_strobe(rxStrobeC), .o_rx_payload(rxPayloadC),
        .o_done(doneC), .o_err_misroute(errMisC), .o_err_overflow(errOvfC), .o_err_extra(errExtC)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic v, input logic [PAYLOAD_SIZE-1:0] payload,
                                 input logic [ADDR_BITS-1:0] dest);
        case (sel)
            0:       begin ifA.valid = v; ifA.item_in = {payload, dest}; end
            1:       begin ifB.valid = v; ifB.item_in = {payload, dest}; end
            default: begin ifC.valid = v; ifC.item_in = {payload, dest}; end
        endcase
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic strobeCheckB();
        if (rxStrobeB) begin
            checkOutput("B_pop_order", 32'(rxPayloadB), 32'(expectB));
            expectB = expectB + 8'd1;
        end
    endtask

    // Registered upstream source: decides each flit on busy as it stood one cycle earlier
    task automatic sendLaggedB(input logic [7:0] base, input int nFlits);
        int sent = 0;
        logic lagBusy = 1'b0;
        for (int s = 0; s < 400 && sent < nFlits; s++) begin
            if (ifB.busy && firstBusyStep < 0) firstBusyStep = s;
            if (!lagBusy) begin
                applyStimulus(1, 1'b1, 8'(base + 8'(sent)), 4'd3);
                sent++;
            end else begin
                applyStimulus(1, 1'b0, 8'h00, 4'd3);
            end
            lagBusy = ifB.busy;
            tick();
            strobeCheckB();
        end
        applyStimulus(1, 1'b0, 8'h00, 4'd3);
    endtask

    // Absolute time limit so the run can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(0, 1'b0, 8'h00, 4'd3);
        applyStimulus(1, 1'b0, 8'h00, 4'd3);
        applyStimulus(2, 1'b0, 8'h00, 4'd3);
        doReset();

        // Reset values
        checkOutput("rst_busy",     32'(ifA.busy),   0);
        checkOutput("rst_rx_count", 32'(rxCountA),   0);
        checkOutput("rst_strobe",   32'(rxStrobeA),  0);
        checkOutput("rst_payload",  32'(rxPayloadA), 0);
        checkOutput("rst_done",     32'(doneA),      0);
        checkOutput("rst_err_mis",  32'(errMisA),    0);
        checkOutput("rst_err_ovf",  32'(errOvfA),    0);
        checkOutput("rst_err_ext",  32'(errExtA),    0);

        // Basic stream: 12 back-to-back flits 0x41..0x4C to node 3
        busyHits = 0;
        applyStimulus(0, 1'b1, 8'h41, 4'd3);
        tick();
        checkOutput("A_latency_strobe", 32'(rxStrobeA), 0);
        checkOutput("A_latency_count",  32'(rxCountA),  0);
        for (int i = 1; i < 12; i++) begin
            applyStimulus(0, 1'b1, 8'(8'h41 + 8'(i)), 4'd3);
            tick();
            if (ifA.busy) busyHits++;
            checkOutput("A_stream_strobe",  32'(rxStrobeA),  1);
            checkOutput("A_stream_payload", 32'(rxPayloadA), 32'h41 + 32'(i - 1));
        end
        checkOutput("A_count_before_last", 32'(rxCountA), 11);
        checkOutput("A_done_early",        32'(doneA),    0);
        applyStimulus(0, 1'b0, 8'h00, 4'd3);
        tick();
        if (ifA.busy) busyHits++;
        checkOutput("A_last_strobe",  32'(rxStrobeA),  1);
        checkOutput("A_last_payload", 32'(rxPayloadA), 32'h4C);
        checkOutput("A_final_count",  32'(rxCountA),   12);
        checkOutput("A_done",         32'(doneA),      1);
        tick();
        checkOutput("A_strobe_pulse", 32'(rxStrobeA), 0);
        for (int i = 0; i < 12; i++) begin
            checkOutput("A_msg_mem", 32'(dutA.msg_mem[i]), 32'h41 + 32'(i));
        end
        checkOutput("A_no_misroute", 32'(errMisA), 0);
        checkOutput("A_no_overflow", 32'(errOvfA), 0);
        checkOutput("A_no_extra",    32'(errExtA), 0);
        checkOutput("A_busy_never",  32'(busyHits), 0);

        // Extra flit after the message is complete
        applyStimulus(0, 1'b1, 8'h99, 4'd3);
        tick();
        checkOutput("A_extra_not_yet", 32'(errExtA), 0);
        applyStimulus(0, 1'b0, 8'h00, 4'd3);
        tick();
        checkOutput("A_extra_strobe",  32'(rxStrobeA),  1);
        checkOutput("A_extra_payload", 32'(rxPayloadA), 32'h99);
        checkOutput("A_extra_count",   32'(rxCountA),   13);
        checkOutput("A_extra_flag",    32'(errExtA),    1);
        checkOutput("A_extra_done",    32'(doneA),      1);
        checkOutput("A_extra_mem11",   32'(dutA.msg_mem[11]), 32'h4C);
        checkOutput("A_extra_mem0",    32'(dutA.msg_mem[0]),  32'h41);

        // Flit presented during reset must not be accepted
        applyStimulus(0, 1'b1, 8'hEE, 4'd3);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(0, 1'b0, 8'h00, 4'd3);
        tick();
        tick();
        tick();
        checkOutput("A_rst_count",   32'(rxCountA), 0);
        checkOutput("A_rst_done",    32'(doneA),    0);
        checkOutput("A_rst_err_ext", 32'(errExtA),  0);

        // Misroute: flit 5 carries destination 5
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1'b1, 8'(8'h10 + 8'(i)), (i == 5) ? 4'd5 : 4'd3);
            tick();
            if (i == 5) checkOutput("A_mis_before", 32'(errMisA), 0);
            if (i == 6) checkOutput("A_mis_after",  32'(errMisA), 1);
        end
        applyStimulus(0, 1'b0, 8'h00, 4'd3);
        tick();
        tick();
        checkOutput("A_mis_count",  32'(rxCountA), 12);
        checkOutput("A_mis_done",   32'(doneA),    1);
        checkOutput("A_mis_flag",   32'(errMisA),  1);
        checkOutput("A_mis_mem5",   32'(dutA.msg_mem[5]), 32'h15);
        checkOutput("A_mis_mem4",   32'(dutA.msg_mem[4]), 32'h14);
        checkOutput("A_mis_no_ext", 32'(errExtA),  0);

        // Overflow on C: valid held 9 cycles; the 9th edge pops and pushes together
        doReset();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(2, 1'b1, 8'(8'hC0 + 8'(k)), 4'd3);
            tick();
            if (k == 1) checkOutput("C_busy_occ2", 32'(ifC.busy), 0);
            if (k == 2) checkOutput("C_busy_occ3", 32'(ifC.busy), 1);
            if (k == 3) checkOutput("C_ovf_full_no_err", 32'(errOvfC), 0);
            if (k == 4) checkOutput("C_ovf_set", 32'(errOvfC), 1);
            if (k == 8) begin
                checkOutput("C_first_pop_strobe",  32'(rxStrobeC),  1);
                checkOutput("C_first_pop_payload", 32'(rxPayloadC), 32'hC0);
            end
        end
        applyStimulus(2, 1'b0, 8'h00, 4'd3);
        for (int w = 0; w < 50; w++) tick();
        checkOutput("C_count",    32'(rxCountC), 5);
        checkOutput("C_ovf_flag", 32'(errOvfC),  1);
        checkOutput("C_done",     32'(doneC),    0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("C_msg_mem", 32'(dutC.msg_mem[i]), 32'hC0 + 32'(i));
        end
        checkOutput("C_mem_push_on_pop", 32'(dutC.msg_mem[4]), 32'hC8);

        // Backpressure on B with a one-cycle-late upstream
        doReset();
        firstBusyStep = -1;
        expectB = 8'h60;
        sendLaggedB(8'h60, 12);
        for (int w = 0; w < 100 && rxCountB != 16'd12; w++) begin
            tick();
            strobeCheckB();
        end
        checkOutput("B_first_busy_step", 32'(firstBusyStep), 3);
        checkOutput("B_no_overflow",     32'(errOvfB),  0);
        checkOutput("B_count",           32'(rxCountB), 12);
        checkOutput("B_done",            32'(doneB),    1);
        for (int i = 0; i < 12; i++) begin
            checkOutput("B_msg_mem", 32'(dutB.msg_mem[i]), 32'h60 + 32'(i));
        end

        // Mid-run reset on B: 7 flits sent, reset after the 5th pop
        doReset();
        expectB = 8'hA0;
        sendLaggedB(8'hA0, 7);
        for (int w = 0; w < 100 && rxCountB != 16'd5; w++) begin
            tick();
            strobeCheckB();
        end
        checkOutput("B_mid_count_5", 32'(rxCountB), 5);
        doReset();
        checkOutput("B_mid_rst_count",  32'(rxCountB),  0);
        checkOutput("B_mid_rst_strobe", 32'(rxStrobeB), 0);
        checkOutput("B_mid_rst_done",   32'(doneB),     0);
        for (int w = 0; w < 12; w++) begin
            tick();
            strobeCheckB();
        end
        checkOutput("B_mid_no_stale", 32'(rxCountB), 0);
        expectB = 8'hB0;
        sendLaggedB(8'hB0, 12);
        for (int w = 0; w < 100 && rxCountB != 16'd12; w++) begin
            tick();
            strobeCheckB();
        end
        checkOutput("B_mid_final_count", 32'(rxCountB), 12);
        checkOutput("B_mid_done",        32'(doneB),    1);
        checkOutput("B_mid_no_extra",    32'(errExtB),  0);
        checkOutput("B_mid_mem0",        32'(dutB.msg_mem[0]),  32'hB0);
        checkOutput("B_mid_mem11",       32'(dutB.msg_mem[11]), 32'hBB);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/par_sink_to_memory.md
# par_sink_to_memory

Destination-side traffic sink for the NoC test harness. Consumes the flits, {payload, destination address}, that a router output port delivers at a node. It buffers them in a small FIFO, applies `busy` backpressure one cycle early, drains at a programmable rate and reassembles the payload stream into a message memory. It flags misrouted flits, overflow and excess flits so the bench can score each node after a run.

## Interface
Parameters:
- `id`, -1, node number of this sink; -1 disables address checking and `$display` logging
- `msg_size`, 12, payload words expected per message; range 1..255
- `fifo_depth`, 4, input FIFO entries, power of two, ≥2
- `drain_period`, 1, cycles per drain opportunity (1 = every cycle); range 1..255

Ports:
- `clk`  in  1  system clock, single clock domain
- `reset`  in  1  synchronous, active-high reset
- `item_in`  in  `PAYLOAD_SIZE+ADDR_BITS`  flit; [`ADDR_BITS`-1:0] = destination, upper bits = payload
- `valid`  in  1  flit present on `item_in` this cycle
- `busy`  out  1  backpressure to the upstream port
- `rx_count`  out  16  flits popped from the FIFO, saturating at 16'hFFFF
- `rx_strobe`  out  1  one-cycle pulse per popped flit
- `rx_payload`  out  `PAYLOAD_SIZE`  payload of the last popped flit
- `done`  out  1  `msg_size` payload words stored
- `err_misroute`  out  1  sticky; a popped flit had destination ≠ `id`
- `err_overflow`  out  1  sticky; a flit arrived while the FIFO was full
- `err_extra`  out  1  sticky; a flit was popped while `done`=1

## Operation
- Accept: a flit is accepted on every rising edge where `valid`=1 and the FIFO is not full. `busy` is not part of the accept condition. Consecutive valid cycles are distinct flits.
- `busy` is registered. It is 1 when the next-cycle occupancy is ≥ `fifo_depth`-1. This leaves one slot for the flit the upstream source launches before it samples `busy`.
- Overflow: `valid`=1 with the FIFO full drops the flit and sets `err_overflow`. The FIFO is not modified.
- Drain counter: counts 0..`drain_period`-1 and wraps. A pop happens only when the counter is 0 and the FIFO is not empty. If the FIFO is empty at that point, the opportunity is lost and the counter keeps running.
- On a pop:
  - `rx_strobe`=1
  - `rx_payload` loads the popped payload
  - `rx_count` increments, saturating
  - if the destination field ≠ `id` and `id` ≠ -1, `err_misroute` is set; the payload is still stored
- FSM:
  - RECV: each pop writes `msg_mem[wr_idx]` and increments `wr_idx`. A pop with `wr_idx`==`msg_size`-1 moves to DONE and sets `done`.
  - DONE: pops still update `rx_*`, do not write memory, and set `err_extra`. DONE exits only on reset.
- Simultaneous push and pop in one cycle: both are performed and occupancy is unchanged. A push into a full FIFO during a pop is accepted, because the full check uses occupancy after the pop.
- `msg_mem` is readable hierarchically by the bench. It is not cleared by reset.

## Timing
- Reset values: `busy`=0, `rx_count`=0, `rx_strobe`=0, `rx_payload`=0, `done`=0, all `err_*`=0. On reset the FIFO is emptied, `wr_idx` and the drain counter are set to 0, and the FSM enters RECV.
- Reset asserted mid-operation discards FIFO contents and in-flight flits in that cycle. No flit is accepted while `reset`=1.
- Latency: a flit accepted at edge t can pop no earlier than edge t+1 (`rx_strobe` high in cycle t+1). The FIFO read is registered, not fall-through.
- `done` rises in the same cycle as the `rx_strobe` of the `msg_size`-th stored flit.
- `busy` changes one edge after the occupancy change that causes it.
- Throughput: with `drain_period`=1, one flit per cycle sustained and `busy` never asserts.

## Structure
- `PAYLOAD_SIZE`, `ADDR_BITS` and `NUM_NODES` come from the shared defines include. No local redefinition.
- Sub-module `sync_fifo`:
  - parameters: width, depth
  - ports: push, pop, din, dout, count, full, empty
  - synchronous reset
  - reused by later router buffers
- The top level holds the drain counter, the FSM, `msg_mem` and the error and statistics registers.

## Test plan
- Basic stream: `id`=3, `drain_period`=1, 12 flits dest=3, payloads 0x41..0x4C back-to-back → `rx_count`=12, `done` on the 12th strobe, `msg_mem`=0x41..0x4C, no errors, `busy` never 1.
- Backpressure: `fifo_depth`=4, `drain_period`=4, upstream honouring `busy` with one-cycle lag, 12 flits → `busy` asserts at occupancy 3, no `err_overflow`, all 12 stored in order.
- Overflow: `drain_period`=8, `valid` held high ignoring `busy` for 8 cycles → `err_overflow`=1, `rx_count` ends at fewer than 8 and equals the number of accepted flits.
- Misroute: `id`=3, one flit with dest=5 among 12 flits → `err_misroute`=1, payload still stored, `done`=1.
- Extra flit: 13 flits → `done` after the 12th, `err_extra`=1 on the 13th, `msg_mem` unchanged.
- Mid-run reset: reset after 5 pops with 2 flits queued, then send 12 fresh flits → counters restart at 0, stale flits never appear, `done` after 12.
